// File: rtl/mux21_rr_arbiter.sv
// rtl/mux21_rr_arbiter.sv - round-robin arbiter driving a shared 2:1 mux with bounded grant tenures
module mux21_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  input  logic             out_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             last
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       last_b, last_b_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       beat;
  logic       final_beat;

  assign y_valid    = (gnt_a & req_a) | (gnt_b & req_b);
  assign beat       = y_valid & out_ready;
  assign final_beat = beat & (cnt == LAST_BEAT);
  assign last       = final_beat;
  assign y          = (gnt_a | gnt_b) ? (s ? b : a) : '0;

  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // Ties go to whoever was not served most recently
        if (req_a && (!req_b || last_b))
          state_nxt = SERVE_A;
        else if (req_b)
          state_nxt = SERVE_B;
      end
      SERVE_A: begin
        if (!req_a || final_beat) begin
          last_b_nxt = 1'b0;
          cnt_nxt    = '0;
          if (req_b)      state_nxt = SERVE_B;
          else if (req_a) state_nxt = SERVE_A;
          else            state_nxt = IDLE;
        end else if (beat) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SERVE_B: begin
        if (!req_b || final_beat) begin
          last_b_nxt = 1'b1;
          cnt_nxt    = '0;
          if (req_a)      state_nxt = SERVE_A;
          else if (req_b) state_nxt = SERVE_B;
          else            state_nxt = IDLE;
        end else if (beat) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grants and select are their own flops so downstream sees glitch-free controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
      cnt    <= '0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      s      <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
      cnt    <= cnt_nxt;
      gnt_a  <= (state_nxt == SERVE_A);
      gnt_b  <= (state_nxt == SERVE_B);
      s      <= (state_nxt == SERVE_B);
    end
  end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// tb/tb_mux21_rr_arbiter.sv - directed and random stimulus checked against a behavioural model
module tb_mux21_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst, req_a, req_b, out_ready;
  logic [WIDTH-1:0] a, b, y;
  logic             gnt_a, gnt_b, s, y_valid, last;

  mux21_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .a(a), .req_b(req_b), .b(b),
    .out_ready(out_ready), .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .y(y),
    .y_valid(y_valid), .last(last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B; beats done in this tenure; who was served last
  int m_owner;
  int m_beats;
  int m_last_served;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner       = 0;
    m_beats       = 0;
    m_last_served = 2;
  endtask

  task automatic step(input logic r, input logic ra, input logic rb,
                      input logic [7:0] da, input logic [7:0] db, input logic rdy);
    logic [7:0] e_y;
    logic       e_valid, e_beat;
    int         self_req, other_req, other;
    rst = r; req_a = ra; req_b = rb; a = da; b = db; out_ready = rdy;
    @(negedge clk);
    e_valid = (m_owner == 1 && ra) || (m_owner == 2 && rb);
    e_y     = (m_owner == 1) ? da : (m_owner == 2) ? db : 8'h00;
    e_beat  = e_valid && rdy;
    check("gnt_a",   {31'b0, gnt_a},   {31'b0, m_owner == 1});
    check("gnt_b",   {31'b0, gnt_b},   {31'b0, m_owner == 2});
    check("s",       {31'b0, s},       {31'b0, m_owner == 2});
    check("y",       {24'b0, y},       {24'b0, e_y});
    check("y_valid", {31'b0, y_valid}, {31'b0, e_valid});
    check("last",    {31'b0, last},    {31'b0, e_beat && (m_beats == MAX_BURST - 1)});
    check("gnt_excl", {31'b0, gnt_a & gnt_b}, 32'd0);
    if (r) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (ra && rb) m_owner = (m_last_served == 1) ? 2 : 1;
      else if (ra)  m_owner = 1;
      else if (rb)  m_owner = 2;
      m_beats = 0;
    end else begin
      other     = 3 - m_owner;
      self_req  = (m_owner == 1) ? int'(ra) : int'(rb);
      other_req = (other == 1) ? int'(ra) : int'(rb);
      if (self_req == 0 || (e_beat && m_beats + 1 == MAX_BURST)) begin
        m_last_served = m_owner;
        m_beats       = 0;
        if (other_req != 0)     m_owner = other;
        else if (self_req == 0) m_owner = 0;
      end else if (e_beat) begin
        m_beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ra, rb;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset then idle
    step(1, 0, 0, 8'h00, 8'h00, 0);
    step(1, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h00, 1);

    // Single requester, re-granted back to back
    step(0, 1, 0, 8'h3C, 8'h00, 1);
    check("single_gnt_latency", {31'b0, gnt_a}, 32'd1);
    check("single_y", {24'b0, y}, 32'h3C);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h3C, 8'h00, 1);

    // Tie from reset and alternation
    step(1, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 8'hAA, 8'h55, 1);

    // Backpressure after first beat
    step(1, 0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 0, 8'h11, 8'h00, 1);
    step(0, 1, 0, 8'h11, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h11, 8'h00, 0);
    check("bp_hold_gnt", {31'b0, gnt_a}, 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h11, 8'h00, 1);

    // Early drop while B waits, then a fresh tie
    step(1, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h21, 8'h42, 1);
    step(0, 0, 1, 8'h21, 8'h42, 1);
    check("drop_gnt_b", {31'b0, gnt_b}, 32'd1);
    check("drop_s", {31'b0, s}, 32'd1);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 8'h21, 8'h42, 1);
    step(0, 0, 0, 8'h21, 8'h42, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h21, 8'h42, 1);

    // Reset in the middle of a B tenure
    step(1, 0, 0, 8'h00, 8'h00, 0);
    step(0, 0, 1, 8'h00, 8'h77, 1);
    step(0, 0, 1, 8'h00, 8'h77, 1);
    step(1, 1, 1, 8'h66, 8'h77, 1);
    check("mid_rst_gnt_b", {31'b0, gnt_b}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h66, 8'h77, 1);

    // Random traffic with sticky requests
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) ra = ~ra;
      if ($urandom_range(3) == 0) rb = ~rb;
      step($urandom_range(99) == 0, ra, rb, 8'($urandom), 8'($urandom),
           $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux21_rr_arbiter.md
Name: mux21_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 2:1 multiplexer datapath. Two requesters (A, B) compete for one output channel. The block owns the mux select `s` and issues grants. It forwards the granted requester's data with a valid/ready handshake and bounds each tenure to MAX_BURST beats so that neither side starves.

Parameters:
WIDTH, 8, data width of requester inputs and output y
MAX_BURST, 4, maximum beats per grant tenure (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_a  input  1  requester A has a beat to send (held high while data valid)
a  input  WIDTH  requester A data
req_b  input  1  requester B has a beat to send
b  input  WIDTH  requester B data
out_ready  input  1  downstream accepts a beat this cycle
gnt_a  output  1  registered; A owns the channel
gnt_b  output  1  registered; B owns the channel
s  output  1  registered mux select: 0 = A, 1 = B
y  output  WIDTH  combinational: (s ? b : a) when a grant is active, else 0
y_valid  output  1  combinational: (gnt_a & req_a) | (gnt_b & req_b)
last  output  1  combinational: y_valid & out_ready & (beat count == MAX_BURST-1)

Behaviour:
- Clocking and reset:
  - One clock `clk`.
  - `rst` is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - state = IDLE; gnt_a = 0; gnt_b = 0; s = 0; beat counter = 0.
  - Round-robin pointer = "B last served", so A wins the first tie.
  - With no grant active, y = 0, y_valid = 0 and last = 0.
- States:
  - IDLE: no grant.
  - SERVE_A: gnt_a = 1, s = 0.
  - SERVE_B: gnt_b = 1, s = 1.
  - gnt_a and gnt_b are never high together.
- Beat: a cycle in SERVE_x where y_valid & out_ready = 1. Each beat increments the 8-bit counter.
- IDLE transitions, evaluated at the clock edge:
  - Only req_a high: go to SERVE_A.
  - Only req_b high: go to SERVE_B.
  - Both high: go to the requester not last served.
  - Neither high: stay in IDLE.
  - Grant latency is 1 cycle: a request raised in cycle N gives a grant visible in cycle N+1.
- Release conditions in SERVE_x:
  - (a) req_x = 0 in a cycle, or
  - (b) a beat occurs with counter == MAX_BURST-1.
  - On release, the pointer records x as last served and the counter clears.
- Next state on release:
  - Other requester's req high: go directly to SERVE_other, with no IDLE bubble.
  - Else, if req_x is still high (burst limit case): re-grant SERVE_x with a fresh counter.
  - Else: go to IDLE.
- No release: stay in SERVE_x and hold the counter when out_ready = 0 (backpressure). The grant is never revoked while req_x is high and fewer than MAX_BURST beats have completed.
- Request drop mid-tenure: releases at the next edge even if out_ready was low. No beat is counted for that cycle.
- MAX_BURST = 1: every beat releases, so the block alternates strictly when both requesters are active.
- s changes only at the same edge as the grants. A new owner's data appears on y in the cycle its grant goes high.
- Reset asserted mid-tenure: at the next edge, return to the reset state. Any in-flight beat that cycle is still counted by downstream if out_ready was high (y_valid is combinational). No grant persists after reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req=0. Required: gnt_a=gnt_b=0, s=0, y=0, y_valid=0 throughout.
- Single requester: req_a=1, a=8'h3C, out_ready=1.
  - gnt_a rises 1 cycle after req_a.
  - y=8'h3C with y_valid=1.
  - last pulses on beat 4 (beat count 3).
  - The grant is re-issued to A with no idle cycle, since B is idle.
- Tie and alternation: req_a=req_b=1 together from reset, a=8'hAA, b=8'h55, out_ready=1.
  - Grant order: A for 4 beats (y=AA), then B for 4 beats (y=55, s=1), then A again.
  - No gap cycles between tenures.
- Backpressure: A granted, out_ready=0 for 3 cycles after beat 1. Required: counter holds, gnt_a stays 1, y_valid=1; the burst ends after 3 further accepted beats.
- Early drop: A granted, req_a falls after 2 beats while req_b=1. Required: next cycle gnt_b=1, s=1; then A wins the next tie.
- Mid-tenure reset: rst=1 during SERVE_B. Required: next cycle IDLE, gnt_b=0, s=0, pointer reset (A wins the following tie).
